prog_exec_ctrl: RTL and testbench
=================================

PROG_EXEC_CTRL -- requirements
Module: prog_exec_ctrl

Interface
REQ-001 Parameter RUN_TIMEOUT, default 1024: max RUN-state cycles before watchdog abort.
REQ-002 Parameter MAX_WORDS, default 64: max instruction words per load (256-byte instruction memory / 4).
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_data  input  8  command/data byte from host link.
REQ-006 rx_valid  input  1  rx_data valid this cycle.
REQ-007 rx_ready  output  1  byte accepted when rx_valid && rx_ready.
REQ-008 halt_detect  input  1  pipeline has retired a HALT instruction.
REQ-009 imem_wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 imem_wr_addr  output  8  byte address of word being written.
REQ-011 imem_wr_data  output  32  instruction word being written.
REQ-012 pc_write_en  output  1  drives PC write_en; holds PC at 0.
REQ-013 cpu_clk_en  output  1  drives pipeline/PC clk_en.
REQ-014 busy  output  1  high whenever state != IDLE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 err  output  1  one-cycle error pulse.

Function
REQ-017 States: IDLE, LOAD_LEN, LOAD_DATA, WRITE, RUN, STEP, PCRST; all outputs registered.
REQ-018 IDLE: rx_ready=1; accepted byte 0x4C 'L' -> LOAD_LEN; 0x43 'C' -> RUN; 0x53 'S' -> STEP; 0x52 'R' -> PCRST; any other byte -> err pulse, stay IDLE.
REQ-019 LOAD_LEN: next accepted byte N; N==0 or N>MAX_WORDS -> err pulse, IDLE; else word counter=N, address=0, byte counter=0 -> LOAD_DATA.
REQ-020 LOAD_DATA: bytes assembled MSB first into 32-bit word; 4th accepted byte -> WRITE.
REQ-021 WRITE: rx_ready=0; imem_wr_en=1 exactly one cycle with current address/word; address +=4, word counter -=1; counter reaches 0 -> IDLE with done pulse, else LOAD_DATA.
REQ-022 pc_write_en=1 in every cycle of LOAD_LEN, LOAD_DATA and WRITE.
REQ-023 RUN: cpu_clk_en=1 each cycle in RUN; rx_ready=1; accepted 0x48 'H' -> IDLE, no done, no err; other bytes dropped silently.
REQ-024 RUN: halt_detect sampled high -> next cycle IDLE, cpu_clk_en=0, done pulse.
REQ-025 RUN: watchdog counts RUN cycles; on RUN_TIMEOUT-th cycle without halt -> IDLE, err pulse; counter cleared on RUN entry.
REQ-026 Priority in RUN same cycle: halt_detect > 'H' abort > watchdog expiry.
REQ-027 STEP: cpu_clk_en=1 for exactly one cycle, then IDLE with done pulse; halt_detect ignored.
REQ-028 PCRST: pc_write_en=1 for exactly one cycle, then IDLE with done pulse.
REQ-029 halt_detect ignored outside RUN; rx_ready=0 in STEP, PCRST, WRITE.
REQ-030 done and err never high in same cycle; imem_wr_en never high outside WRITE.

Reset
REQ-031 reset high at any clock edge: state IDLE; rx_ready=0 that cycle then 1; all other outputs 0; address, counters, assembled word cleared.
REQ-032 Reset mid-load discards partial word; no imem_wr_en issued; memory contents already written unchanged.
REQ-033 Reset mid-RUN drops cpu_clk_en the following cycle; no done/err pulse.

Verification
REQ-034 'L',0x02, bytes 11 22 33 44 AA BB CC DD -> writes 0x11223344@0x00, 0xAABBCCDD@0x04, one cycle each; pc_write_en high throughout; done after 2nd write.
REQ-035 'L',0x00 and 'L',0x41 -> err pulse each, no imem_wr_en, IDLE.
REQ-036 'C', halt_detect at 10th RUN cycle -> cpu_clk_en high 10 cycles, then 0, done pulse.
REQ-037 'C', no halt, RUN_TIMEOUT=16 -> cpu_clk_en high 16 cycles, err pulse, IDLE; 'C' with halt_detect and 'H' same cycle -> done, not abort.
REQ-038 'S' -> single cpu_clk_en cycle + done; 'R' -> single pc_write_en cycle + done; 0x7A -> err.
REQ-039 reset after 2 of 4 data bytes -> no write, IDLE; fresh 'L',0x01 + 4 bytes writes at 0x00.

Source files
------------

// File: rtl/prog_exec_ctrl.sv
// rtl/prog_exec_ctrl.sv - host-command sequencer: instruction load, run/step, PC reset
// Every output is a flop updated on the same edge that moves the FSM.
module prog_exec_ctrl #(
  parameter int RUN_TIMEOUT = 1024,
  parameter int MAX_WORDS   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        halt_detect,
  output logic        imem_wr_en,
  output logic [7:0]  imem_wr_addr,
  output logic [31:0] imem_wr_data,
  output logic        pc_write_en,
  output logic        cpu_clk_en,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int WCW = $clog2(MAX_WORDS + 1);
  localparam int TW  = $clog2(RUN_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD_LEN, LOAD_DATA, WRITE, RUN, STEP, PCRST} state_t;

  state_t         state;
  logic [WCW-1:0] word_cnt;
  logic [1:0]     byte_cnt;
  logic [7:0]     addr;
  logic [23:0]    word_buf;
  logic [TW-1:0]  wd_cnt;
  logic           accept;

  assign accept = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rx_ready     <= 1'b0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      pc_write_en  <= 1'b0;
      cpu_clk_en   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      word_cnt     <= '0;
      byte_cnt     <= '0;
      addr         <= '0;
      word_buf     <= '0;
      wd_cnt       <= '0;
    end else begin
      done       <= 1'b0;
      err        <= 1'b0;
      imem_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          rx_ready <= 1'b1;
          if (accept) begin
            case (rx_data)
              8'h4C: begin
                state       <= LOAD_LEN;
                busy        <= 1'b1;
                pc_write_en <= 1'b1;
              end
              8'h43: begin
                state      <= RUN;
                busy       <= 1'b1;
                cpu_clk_en <= 1'b1;
                wd_cnt     <= '0;
              end
              8'h53: begin
                state      <= STEP;
                busy       <= 1'b1;
                cpu_clk_en <= 1'b1;
                rx_ready   <= 1'b0;
              end
              8'h52: begin
                state       <= PCRST;
                busy        <= 1'b1;
                pc_write_en <= 1'b1;
                rx_ready    <= 1'b0;
              end
              default: err <= 1'b1;
            endcase
          end
        end
        LOAD_LEN: begin
          if (accept) begin
            if (rx_data == 8'h00 || int'(rx_data) > MAX_WORDS) begin
              state       <= IDLE;
              busy        <= 1'b0;
              pc_write_en <= 1'b0;
              err         <= 1'b1;
            end else begin
              state    <= LOAD_DATA;
              word_cnt <= WCW'(rx_data);
              addr     <= '0;
              byte_cnt <= '0;
            end
          end
        end
        LOAD_DATA: begin
          if (accept) begin
            if (byte_cnt == 2'd3) begin
              state        <= WRITE;
              rx_ready     <= 1'b0;
              imem_wr_en   <= 1'b1;
              imem_wr_addr <= addr;
              imem_wr_data <= {word_buf, rx_data};
            end else begin
              word_buf <= {word_buf[15:0], rx_data};
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        WRITE: begin
          addr     <= addr + 8'd4;
          word_cnt <= word_cnt - WCW'(1);
          byte_cnt <= '0;
          word_buf <= '0;
          rx_ready <= 1'b1;
          if (word_cnt == WCW'(1)) begin
            state       <= IDLE;
            busy        <= 1'b0;
            pc_write_en <= 1'b0;
            done        <= 1'b1;
          end else begin
            state <= LOAD_DATA;
          end
        end
        RUN: begin
          // Halt wins over a same-cycle 'H' abort, which wins over watchdog expiry.
          if (halt_detect || (accept && rx_data == 8'h48) || wd_cnt == TW'(RUN_TIMEOUT - 1)) begin
            state      <= IDLE;
            busy       <= 1'b0;
            cpu_clk_en <= 1'b0;
            done       <= halt_detect;
            err        <= !halt_detect && !(accept && rx_data == 8'h48);
          end else begin
            wd_cnt <= wd_cnt + TW'(1);
          end
        end
        STEP, PCRST: begin
          state       <= IDLE;
          busy        <= 1'b0;
          cpu_clk_en  <= 1'b0;
          pc_write_en <= 1'b0;
          rx_ready    <= 1'b1;
          done        <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          rx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_exec_ctrl.sv
// tb/tb_prog_exec_ctrl.sv - directed checks of prog_exec_ctrl with RUN_TIMEOUT=16
module tb_prog_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        halt_detect = 1'b0;
  logic        imem_wr_en;
  logic [7:0]  imem_wr_addr;
  logic [31:0] imem_wr_data;
  logic        pc_write_en;
  logic        cpu_clk_en;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  prog_exec_ctrl #(.RUN_TIMEOUT(16), .MAX_WORDS(64)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .halt_detect(halt_detect), .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data), .pc_write_en(pc_write_en), .cpu_clk_en(cpu_clk_en),
    .busy(busy), .done(done), .err(err)
  );

  int n_cmp = 0;
  int n_fail = 0;

  int c_wr = 0, c_done = 0, c_err = 0, c_cpu = 0, c_pcw = 0, c_busy = 0, c_both = 0, c_stray = 0;
  logic [7:0]  la [0:15];
  logic [31:0] ld [0:15];
  int s_wr, s_done, s_err, s_cpu, s_pcw, s_busy;

  always @(negedge clk) begin
    if (imem_wr_en) begin
      if (c_wr < 16) begin
        la[c_wr] <= imem_wr_addr;
        ld[c_wr] <= imem_wr_data;
      end
      c_wr <= c_wr + 1;
      if (pc_write_en !== 1'b1) c_stray <= c_stray + 1;
    end
    if (done) c_done <= c_done + 1;
    if (err) c_err <= c_err + 1;
    if (done && err) c_both <= c_both + 1;
    if (cpu_clk_en) c_cpu <= c_cpu + 1;
    if (pc_write_en) c_pcw <= c_pcw + 1;
    if (busy) c_busy <= c_busy + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_wr = c_wr; s_done = c_done; s_err = c_err; s_cpu = c_cpu; s_pcw = c_pcw; s_busy = c_busy;
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("send_ready", {31'b0, rx_ready}, 32'd1);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("idle_reached", {31'b0, busy}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    check("rst_outputs", {26'b0, busy, done, err, imem_wr_en, pc_write_en, cpu_clk_en}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_rx_ready_after", {31'b0, rx_ready}, 32'd1);

    // two-word load
    snap();
    send(8'h4C); send(8'h02);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    wait_idle();
    check("load2_writes", c_wr - s_wr, 32'd2);
    check("load2_addr0", {24'b0, la[s_wr]}, 32'h00);
    check("load2_data0", ld[s_wr], 32'h11223344);
    check("load2_addr1", {24'b0, la[s_wr+1]}, 32'h04);
    check("load2_data1", ld[s_wr+1], 32'hAABBCCDD);
    check("load2_done", c_done - s_done, 32'd1);
    check("load2_err", c_err - s_err, 32'd0);
    check("load2_pcw_busy", c_pcw - s_pcw, c_busy - s_busy);

    // bad lengths
    snap();
    send(8'h4C); send(8'h00);
    wait_idle();
    check("len0_err", c_err - s_err, 32'd1);
    check("len0_writes", c_wr - s_wr, 32'd0);
    snap();
    send(8'h4C); send(8'h41);
    wait_idle();
    check("len41_err", c_err - s_err, 32'd1);
    check("len41_writes", c_wr - s_wr, 32'd0);
    check("len41_done", c_done - s_done, 32'd0);

    // run, halt on 10th RUN cycle
    snap();
    send(8'h43);
    check("run_busy", {31'b0, busy}, 32'd1);
    repeat (9) @(negedge clk);
    halt_detect = 1'b1;
    @(negedge clk);
    halt_detect = 1'b0;
    check("halt_cpu_off", {31'b0, cpu_clk_en}, 32'd0);
    wait_idle();
    check("halt_cpu_cycles", c_cpu - s_cpu, 32'd10);
    check("halt_done", c_done - s_done, 32'd1);
    check("halt_err", c_err - s_err, 32'd0);

    // watchdog
    snap();
    send(8'h43);
    wait_idle();
    check("wd_cpu_cycles", c_cpu - s_cpu, 32'd16);
    check("wd_err", c_err - s_err, 32'd1);
    check("wd_done", c_done - s_done, 32'd0);

    // halt and 'H' in the same cycle
    snap();
    send(8'h43);
    @(negedge clk);
    rx_data = 8'h48; rx_valid = 1'b1; halt_detect = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; halt_detect = 1'b0;
    check("haltH_idle", {31'b0, busy}, 32'd0);
    wait_idle();
    check("haltH_done", c_done - s_done, 32'd1);
    check("haltH_err", c_err - s_err, 32'd0);
    check("haltH_cpu", c_cpu - s_cpu, 32'd2);

    // 'H' abort alone
    snap();
    send(8'h43); send(8'h48);
    check("abort_idle", {31'b0, busy}, 32'd0);
    wait_idle();
    check("abort_pulses", (c_done - s_done) + (c_err - s_err), 32'd0);
    check("abort_cpu", c_cpu - s_cpu, 32'd2);

    // reset during RUN
    snap();
    send(8'h43);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstrun_cpu", {31'b0, cpu_clk_en}, 32'd0);
    check("rstrun_rx_ready", {31'b0, rx_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rstrun_pulses", (c_done - s_done) + (c_err - s_err), 32'd0);
    check("rstrun_busy", {31'b0, busy}, 32'd0);

    // step, pc reset, unknown command
    snap();
    send(8'h53);
    wait_idle();
    check("step_cpu", c_cpu - s_cpu, 32'd1);
    check("step_done", c_done - s_done, 32'd1);
    snap();
    send(8'h52);
    wait_idle();
    check("pcrst_pcw", c_pcw - s_pcw, 32'd1);
    check("pcrst_done", c_done - s_done, 32'd1);
    check("pcrst_cpu", c_cpu - s_cpu, 32'd0);
    snap();
    send(8'h7A);
    wait_idle();
    check("bad_cmd_err", c_err - s_err, 32'd1);
    check("bad_cmd_done", c_done - s_done, 32'd0);

    // reset mid-load, then fresh single-word load
    snap();
    send(8'h4C); send(8'h01); send(8'hAA); send(8'hBB);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rstload_writes", c_wr - s_wr, 32'd0);
    check("rstload_busy", {31'b0, busy}, 32'd0);
    snap();
    send(8'h4C); send(8'h01);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    wait_idle();
    check("reload_writes", c_wr - s_wr, 32'd1);
    check("reload_addr", {24'b0, la[s_wr]}, 32'h00);
    check("reload_data", ld[s_wr], 32'hDEADBEEF);
    check("reload_done", c_done - s_done, 32'd1);

    check("done_err_overlap", c_both, 32'd0);
    check("write_without_pcw", c_stray, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
